// File: rtl/rtc_pkg.sv
// Shared encodings and BCD helpers for the multi-alarm RTC: write-field codes,
// BCD limits, validity check, wrapping increment and 12 h display conversion.
package rtc_pkg;

  typedef enum logic [1:0] {
    FLD_SEC   = 2'd0,
    FLD_MIN   = 2'd1,
    FLD_HOUR  = 2'd2,
    FLD_ALARM = 2'd3
  } wr_field_e;

  localparam logic [7:0] BCD_LIM_59 = 8'h59;
  localparam logic [7:0] BCD_LIM_23 = 8'h23;

  function automatic logic bcd_valid(input logic [7:0] v, input logic [7:0] lim);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= lim);
  endfunction

  // Returns {carry, next}; values at or above the limit wrap so a corrupted field self-recovers.
  function automatic logic [8:0] bcd_inc_wrap(input logic [7:0] v, input logic [7:0] lim);
    logic [8:0] r;
    if (v >= lim) begin
      r = {1'b1, 8'h00};
    end else if (v[3:0] == 4'd9) begin
      r = {1'b0, v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {1'b0, v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Returns {pm, hour12} for a BCD hour 00..23.
  function automatic logic [8:0] to_12h(input logic [7:0] h);
    logic [7:0] bin;
    logic [7:0] b12;
    logic [8:0] r;
    bin = ({4'd0, h[7:4]} * 8'd10) + {4'd0, h[3:0]};
    b12 = bin - 8'd12;
    if (bin == 8'd0) begin
      r = {1'b0, 8'h12};
    end else if (bin < 8'd12) begin
      r = {1'b0, h};
    end else if (bin == 8'd12) begin
      r = {1'b1, 8'h12};
    end else begin
      r = {1'b1, (b12 >= 8'd10) ? (8'h10 + (b12 - 8'd10)) : b12};
    end
    return r;
  endfunction

endpackage

// File: rtl/rtc_multi_alarm_if.sv
// Register-style write port of the RTC: strobe, field select, data, alarm slot
// and the rejected-write pulse returned by the clock core.
interface rtc_multi_alarm_if #(
  parameter int AW = 1
);
  import rtc_pkg::*;

  logic          wr_stb;
  wr_field_e     wr_field;
  logic [15:0]   wr_data;
  logic [AW-1:0] wr_sel;
  logic          wr_err;

  modport master (output wr_stb, wr_field, wr_data, wr_sel, input wr_err);
  modport slave  (input wr_stb, wr_field, wr_data, wr_sel, output wr_err);
endinterface

// File: rtl/rtc_prescaler.sv
// Divides the input clock down to one advance per second; hold parks it at 0,
// zero restarts the second. colon_o is high for the first half of each second.
module rtc_prescaler #(
  parameter int CLK_HZ = 50000000
) (
  input  logic clk,
  input  logic clr,
  input  logic hold_i,
  input  logic zero_i,
  output logic tick_o,
  output logic colon_o
);

  localparam int            CW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLK_HZ - 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_HZ / 2);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          colon_q;

  always_comb begin
    tick_o = (cnt_q == TERM) && !hold_i;
    if (hold_i || zero_i || tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // colon is registered from the next count so it tracks the live count exactly.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q   <= '0;
      colon_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      colon_q <= (cnt_d < HALF);
    end
  end

  assign colon_o = colon_q;

endmodule

// File: rtl/rtc_multi_alarm.sv
// BCD time-of-day core with NUM_ALARMS latched alarms, validated writes and
// 12/24 h display. Optional top-of-hour chime built only when RTC_CHIME_EN is defined.
module rtc_multi_alarm
  import rtc_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int NUM_ALARMS = 2,
  parameter int AW         = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  set_en,
  rtc_multi_alarm_if.slave      wr,
  input  logic [NUM_ALARMS-1:0] alarm_arm,
  input  logic                  alarm_ack,
  input  logic                  mode12,
  output logic [7:0]            sec_bcd,
  output logic [7:0]            min_bcd,
  output logic [7:0]            hour_bcd,
  output logic                  pm,
  output logic                  tick_1hz,
  output logic                  colon,
  output logic [NUM_ALARMS-1:0] ring,
  output logic                  chime
);

  logic [7:0]            sec_q, min_q, hr_q;
  logic [7:0]            sec_d, min_d, hr_d;
  logic [7:0]            al_hr_q  [NUM_ALARMS];
  logic [7:0]            al_min_q [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] ring_q, ring_d, al_wr_s, match_s;
  logic [7:0]            sec_bcd_q, min_bcd_q, hour_bcd_q;
  logic                  pm_q, tick_q, wr_err_q;

  logic [AW-1:0] sel_s;
  logic          adv_s, colon_s, wr_ok_s;
  logic          wr_sec_s, wr_min_s, wr_hr_s, wr_al_s;
  logic [8:0]    sec_inc_s, min_inc_s, hr_inc_s, h12_s;
  logic [7:0]    min_adv_s, hr_adv_s;
  logic          unused_day_s;

  assign sel_s        = wr.wr_sel;
  assign unused_day_s = hr_inc_s[8];

  rtc_prescaler #(.CLK_HZ(CLK_HZ)) u_presc (
    .clk     (clk),
    .clr     (clr),
    .hold_i  (set_en),
    .zero_i  (wr_sec_s),
    .tick_o  (adv_s),
    .colon_o (colon_s)
  );

  // Write validation and per-field apply strobes.
  always_comb begin
    case (wr.wr_field)
      FLD_SEC, FLD_MIN: wr_ok_s = bcd_valid(wr.wr_data[7:0], BCD_LIM_59);
      FLD_HOUR:         wr_ok_s = bcd_valid(wr.wr_data[7:0], BCD_LIM_23);
      FLD_ALARM:        wr_ok_s = bcd_valid(wr.wr_data[15:8], BCD_LIM_23) &&
                                  bcd_valid(wr.wr_data[7:0], BCD_LIM_59) &&
                                  (int'(sel_s) < NUM_ALARMS);
      default:          wr_ok_s = 1'b0;
    endcase
    wr_sec_s = wr.wr_stb && wr_ok_s && (wr.wr_field == FLD_SEC);
    wr_min_s = wr.wr_stb && wr_ok_s && (wr.wr_field == FLD_MIN);
    wr_hr_s  = wr.wr_stb && wr_ok_s && (wr.wr_field == FLD_HOUR);
    wr_al_s  = wr.wr_stb && wr_ok_s && (wr.wr_field == FLD_ALARM);
  end

  // Time carry chain; a write overrides only its own field, matches use the pure tick result.
  always_comb begin
    sec_inc_s = bcd_inc_wrap(sec_q, BCD_LIM_59);
    min_inc_s = bcd_inc_wrap(min_q, BCD_LIM_59);
    hr_inc_s  = bcd_inc_wrap(hr_q, BCD_LIM_23);
    min_adv_s = sec_inc_s[8] ? min_inc_s[7:0] : min_q;
    hr_adv_s  = (sec_inc_s[8] && min_inc_s[8]) ? hr_inc_s[7:0] : hr_q;
    sec_d = wr_sec_s ? wr.wr_data[7:0] : (adv_s ? sec_inc_s[7:0] : sec_q);
    min_d = wr_min_s ? wr.wr_data[7:0] : (adv_s ? min_adv_s : min_q);
    hr_d  = wr_hr_s  ? wr.wr_data[7:0] : (adv_s ? hr_adv_s : hr_q);
    for (int i = 0; i < NUM_ALARMS; i++) begin
      al_wr_s[i] = wr_al_s && (int'(sel_s) == i);
      match_s[i] = adv_s && alarm_arm[i] && (sec_inc_s[7:0] == 8'h00) &&
                   (min_adv_s == al_min_q[i]) && (hr_adv_s == al_hr_q[i]);
      ring_d[i]  = match_s[i] || (ring_q[i] && !alarm_ack && alarm_arm[i]);
    end
    h12_s = to_12h(hr_q);
  end

  // Time, alarm slots, ring flags and the registered display outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      sec_q      <= 8'h00;
      min_q      <= 8'h00;
      hr_q       <= 8'h00;
      ring_q     <= '0;
      sec_bcd_q  <= 8'h00;
      min_bcd_q  <= 8'h00;
      hour_bcd_q <= 8'h00;
      pm_q       <= 1'b0;
      tick_q     <= 1'b0;
      wr_err_q   <= 1'b0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        al_hr_q[i]  <= 8'h12;
        al_min_q[i] <= 8'h00;
      end
    end else begin
      sec_q      <= sec_d;
      min_q      <= min_d;
      hr_q       <= hr_d;
      ring_q     <= ring_d;
      sec_bcd_q  <= sec_q;
      min_bcd_q  <= min_q;
      hour_bcd_q <= mode12 ? h12_s[7:0] : hr_q;
      pm_q       <= mode12 && h12_s[8];
      tick_q     <= adv_s;
      wr_err_q   <= wr.wr_stb && !wr_ok_s;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (al_wr_s[i]) begin
          al_hr_q[i]  <= wr.wr_data[15:8];
          al_min_q[i] <= wr.wr_data[7:0];
        end else begin
          al_hr_q[i]  <= al_hr_q[i];
          al_min_q[i] <= al_min_q[i];
        end
      end
    end
  end

`ifdef RTC_CHIME_EN
  logic chime_q;

  // Top-of-hour chime: seconds 00..04 of minute 00, gated by the colon half-second.
  always_ff @(posedge clk) begin
    if (clr) begin
      chime_q <= 1'b0;
    end else begin
      chime_q <= !set_en && colon_s && (min_q == 8'h00) && (sec_q <= 8'h04);
    end
  end

  assign chime = chime_q;
`else
  assign chime = 1'b0;
`endif

  assign sec_bcd   = sec_bcd_q;
  assign min_bcd   = min_bcd_q;
  assign hour_bcd  = hour_bcd_q;
  assign pm        = pm_q;
  assign tick_1hz  = tick_q;
  assign colon     = colon_s;
  assign ring      = ring_q;
  assign wr.wr_err = wr_err_q;

endmodule

// File: tb/tb_rtc_multi_alarm.sv
// Self-checking bench for rtc_multi_alarm with CLK_HZ=4: write table with a
// scoreboard queue, plus sequences for rollover, hold, alarms and reset.
module tb_rtc_multi_alarm;
  import rtc_pkg::*;

  localparam int CLK_HZ     = 4;
  localparam int NUM_ALARMS = 2;
  localparam int AW         = 2;

`ifdef RTC_CHIME_EN
  localparam logic EXP_CHIME_TOP = 1'b1;
`else
  localparam logic EXP_CHIME_TOP = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  clr, set_en, alarm_ack, mode12;
  logic [NUM_ALARMS-1:0] alarm_arm, ring;
  logic [7:0]            sec_bcd, min_bcd, hour_bcd;
  logic                  pm, tick_1hz, colon, chime;
  int                    n_checks = 0;
  int                    n_fail   = 0;

  rtc_multi_alarm_if #(.AW(AW)) wr_if ();

  rtc_multi_alarm #(.CLK_HZ(CLK_HZ), .NUM_ALARMS(NUM_ALARMS), .AW(AW)) dut (
    .clk       (clk),
    .clr       (clr),
    .set_en    (set_en),
    .wr        (wr_if),
    .alarm_arm (alarm_arm),
    .alarm_ack (alarm_ack),
    .mode12    (mode12),
    .sec_bcd   (sec_bcd),
    .min_bcd   (min_bcd),
    .hour_bcd  (hour_bcd),
    .pm        (pm),
    .tick_1hz  (tick_1hz),
    .colon     (colon),
    .ring      (ring),
    .chime     (chime)
  );

  always #5 clk = ~clk;

  typedef struct {
    wr_field_e     fld;
    logic [15:0]   data;
    logic [AW-1:0] sel;
    logic          m12;
    logic          err;
    logic [7:0]    sec;
    logic [7:0]    min;
    logic [7:0]    hr;
    logic          pm;
  } vec_t;

  vec_t tbl [15];
  vec_t sb_q [$];
  vec_t cur;

  logic       exp_colon [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic       exp_tick  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [7:0] exp_sec   [5] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
  int         tick_seen;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_tick(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tick_1hz !== 1'b1 && n < 12);
    check(name, 16'(n), 16'd4);
  endtask

  task automatic do_write(input wr_field_e f, input logic [15:0] d);
    wr_if.wr_field = f;
    wr_if.wr_data  = d;
    wr_if.wr_sel   = '0;
    wr_if.wr_stb   = 1'b1;
    @(negedge clk);
    check("do_write_err", 16'(wr_if.wr_err), 16'd0);
    wr_if.wr_stb = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    clr = 1'b1; set_en = 1'b0; alarm_arm = '0; alarm_ack = 1'b0; mode12 = 1'b0;
    wr_if.wr_stb = 1'b0; wr_if.wr_field = FLD_SEC; wr_if.wr_data = 16'h0000; wr_if.wr_sel = '0;

    //          fld        data      sel   m12   err   sec    min    hr     pm
    tbl[0]  = '{FLD_HOUR,  16'h0023, 2'd0, 1'b0, 1'b0, 8'h01, 8'h00, 8'h23, 1'b0};
    tbl[1]  = '{FLD_MIN,   16'h0059, 2'd0, 1'b0, 1'b0, 8'h01, 8'h59, 8'h23, 1'b0};
    tbl[2]  = '{FLD_SEC,   16'h0059, 2'd0, 1'b0, 1'b0, 8'h59, 8'h59, 8'h23, 1'b0};
    tbl[3]  = '{FLD_MIN,   16'h0060, 2'd0, 1'b0, 1'b1, 8'h59, 8'h59, 8'h23, 1'b0};
    tbl[4]  = '{FLD_HOUR,  16'h001A, 2'd0, 1'b0, 1'b1, 8'h59, 8'h59, 8'h23, 1'b0};
    tbl[5]  = '{FLD_SEC,   16'h005A, 2'd0, 1'b0, 1'b1, 8'h59, 8'h59, 8'h23, 1'b0};
    tbl[6]  = '{FLD_ALARM, 16'h0730, 2'd3, 1'b0, 1'b1, 8'h59, 8'h59, 8'h23, 1'b0};
    tbl[7]  = '{FLD_ALARM, 16'h0730, 2'd1, 1'b0, 1'b0, 8'h59, 8'h59, 8'h23, 1'b0};
    tbl[8]  = '{FLD_ALARM, 16'h2400, 2'd0, 1'b0, 1'b1, 8'h59, 8'h59, 8'h23, 1'b0};
    tbl[9]  = '{FLD_ALARM, 16'h0731, 2'd0, 1'b0, 1'b0, 8'h59, 8'h59, 8'h23, 1'b0};
    tbl[10] = '{FLD_HOUR,  16'h0000, 2'd0, 1'b1, 1'b0, 8'h59, 8'h59, 8'h12, 1'b0};
    tbl[11] = '{FLD_HOUR,  16'h0013, 2'd0, 1'b1, 1'b0, 8'h59, 8'h59, 8'h01, 1'b1};
    tbl[12] = '{FLD_HOUR,  16'h0012, 2'd0, 1'b1, 1'b0, 8'h59, 8'h59, 8'h12, 1'b1};
    tbl[13] = '{FLD_HOUR,  16'h0023, 2'd0, 1'b1, 1'b0, 8'h59, 8'h59, 8'h11, 1'b1};
    tbl[14] = '{FLD_HOUR,  16'h0023, 2'd0, 1'b0, 1'b0, 8'h59, 8'h59, 8'h23, 1'b0};

    repeat (2) @(negedge clk);
    check("rst_sec",   16'(sec_bcd),      16'h0000);
    check("rst_min",   16'(min_bcd),      16'h0000);
    check("rst_hour",  16'(hour_bcd),     16'h0000);
    check("rst_pm",    16'(pm),           16'd0);
    check("rst_tick",  16'(tick_1hz),     16'd0);
    check("rst_colon", 16'(colon),        16'd1);
    check("rst_ring",  16'(ring),         16'd0);
    check("rst_err",   16'(wr_if.wr_err), 16'd0);
    check("rst_chime", 16'(chime),        16'd0);
    clr = 1'b0;

    // Free run through the first second.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("run_colon", 16'(colon),    16'(exp_colon[k]));
      check("run_tick",  16'(tick_1hz), 16'(exp_tick[k]));
      check("run_sec",   16'(sec_bcd),  16'(exp_sec[k]));
    end

    // Write table, time frozen.
    set_en = 1'b1;
    for (int i = 0; i < 15; i++) begin
      mode12         = tbl[i].m12;
      wr_if.wr_field = tbl[i].fld;
      wr_if.wr_data  = tbl[i].data;
      wr_if.wr_sel   = tbl[i].sel;
      wr_if.wr_stb   = 1'b1;
      sb_q.push_back(tbl[i]);
      @(negedge clk);
      wr_if.wr_stb = 1'b0;
      cur = sb_q.pop_front();
      check("tbl_err",       16'(wr_if.wr_err), 16'(cur.err));
      @(negedge clk);
      check("tbl_err_pulse", 16'(wr_if.wr_err), 16'd0);
      check("tbl_sec",       16'(sec_bcd),      16'(cur.sec));
      check("tbl_min",       16'(min_bcd),      16'(cur.min));
      check("tbl_hour",      16'(hour_bcd),     16'(cur.hr));
      check("tbl_pm",        16'(pm),           16'(cur.pm));
    end

    // 23:59:59 rollover.
    set_en = 1'b0;
    wait_tick("rollover_tick_delay");
    @(negedge clk);
    check("roll_sec",   16'(sec_bcd),  16'h0000);
    check("roll_min",   16'(min_bcd),  16'h0000);
    check("roll_hour",  16'(hour_bcd), 16'h0000);
    check("roll_tick",  16'(tick_1hz), 16'd0);
    check("roll_chime", 16'(chime),    16'(EXP_CHIME_TOP));

    // Hold for 20 cycles.
    set_en    = 1'b1;
    tick_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (tick_1hz === 1'b1) tick_seen++;
    end
    check("hold_ticks", 16'(tick_seen), 16'd0);
    check("hold_sec",   16'(sec_bcd),   16'h0000);
    check("hold_chime", 16'(chime),     16'd0);
    set_en = 1'b0;
    wait_tick("release_tick_delay");
    @(negedge clk);
    check("release_sec", 16'(sec_bcd), 16'h0001);

    // Alarm slot 1 at 07:30.
    set_en    = 1'b1;
    alarm_arm = 2'b11;
    do_write(FLD_HOUR, 16'h0007);
    do_write(FLD_MIN,  16'h0029);
    do_write(FLD_SEC,  16'h0059);
    set_en = 1'b0;
    wait_tick("alarm_tick_delay");
    check("ring_slot1", 16'(ring), 16'b10);
    @(negedge clk);
    check("ring_latched", 16'(ring),     16'b10);
    check("alarm_min",    16'(min_bcd),  16'h0030);
    check("alarm_hour",   16'(hour_bcd), 16'h0007);

    // Ack coinciding with the slot 0 match at 07:31:00.
    set_en = 1'b1;
    do_write(FLD_SEC, 16'h0059);
    set_en = 1'b0;
    repeat (3) @(negedge clk);
    alarm_ack = 1'b1;
    @(negedge clk);
    alarm_ack = 1'b0;
    check("ack_tick_align", 16'(tick_1hz), 16'd1);
    check("ack_vs_match",   16'(ring),     16'b01);
    alarm_arm = 2'b10;
    @(negedge clk);
    check("disarm_clear", 16'(ring), 16'b00);

    // Reset wins over a coincident write.
    clr            = 1'b1;
    wr_if.wr_field = FLD_HOUR;
    wr_if.wr_data  = 16'h0005;
    wr_if.wr_stb   = 1'b1;
    @(negedge clk);
    clr          = 1'b0;
    wr_if.wr_stb = 1'b0;
    check("clr_err",  16'(wr_if.wr_err), 16'd0);
    check("clr_hour", 16'(hour_bcd),     16'h0000);
    @(negedge clk);
    check("clr_hour_int", 16'(hour_bcd), 16'h0000);
    check("clr_min_int",  16'(min_bcd),  16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
